// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point multiply/divide datapath blocks:
// multiplier FSM states, rounding shift and saturation limits.
package fixed_point_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } mult_state_t;

  // Right shift taking a Q1.(in_w-1) x Q1.(in_w-1) product to Q1.(out_w-1).
  function automatic int calc_shift(input int in_w, input int out_w);
    return 2 * (in_w - 1) - (out_w - 1);
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Magnitude + sign to signed Q1.(OUT_WIDTH-1): round half away from zero on
// the magnitude, then clamp to the representable range.
module fxp_round_sat
  import fixed_point_pkg::*;
#(
  parameter int ACC_W     = 24,
  parameter int OUT_WIDTH = 12,
  parameter int SHIFT     = 11
) (
  input  logic [ACC_W-1:0]            mag_i,
  input  logic                        sign_i,
  output logic signed [OUT_WIDTH-1:0] res_o
);

  localparam int HS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [ACC_W:0] ONE      = {{ACC_W{1'b0}}, 1'b1};
  localparam logic [ACC_W:0] HALF     = (SHIFT > 0) ? (ONE << HS) : '0;
  localparam logic [ACC_W:0] POS_LIM  = (ONE << (OUT_WIDTH - 1)) - ONE;
  localparam logic [ACC_W:0] NEG_LIM  = ONE << (OUT_WIDTH - 1);
  localparam logic signed [OUT_WIDTH-1:0] MAX_POS = OUT_WIDTH'(sat_max(OUT_WIDTH));
  localparam logic signed [OUT_WIDTH-1:0] MIN_NEG = OUT_WIDTH'(sat_min(OUT_WIDTH));

  // One extra bit so the rounding increment cannot wrap the magnitude.
  function automatic logic [ACC_W:0] round_mag(input logic [ACC_W-1:0] m);
    logic [ACC_W:0] sum;
    sum = {1'b0, m} + HALF;
    return sum >> SHIFT;
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic [ACC_W:0] m,
                                                           input logic        s);
    logic [OUT_WIDTH-1:0] low;
    low = m[OUT_WIDTH-1:0];
    if (!s && (m > POS_LIM)) return MAX_POS;
    if (s && (m > NEG_LIM))  return MIN_NEG;
    return s ? signed'(-low) : signed'(low);
  endfunction

  always_comb begin
    res_o = saturate(round_mag(mag_i), sign_i);
  end

endmodule

// File: rtl/fixed_point_multiplier.sv
// Sequential signed Q1.(N-1) multiplier: radix-2 shift-add over operand
// magnitudes for IN_WIDTH cycles, then one cycle of sign fix/round/saturate.
module fixed_point_multiplier
  import fixed_point_pkg::*;
#(
  parameter int IN_WIDTH  = 12,
  parameter int OUT_WIDTH = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [IN_WIDTH-1:0]  rs1,
  input  logic signed [IN_WIDTH-1:0]  rs2,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [OUT_WIDTH-1:0] rd,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int ACC_W = 2 * IN_WIDTH;
  localparam int SHIFT = calc_shift(IN_WIDTH, OUT_WIDTH);
  localparam int CNT_W = $clog2(IN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(IN_WIDTH - 1);

  mult_state_t                 state_q, state_d;
  logic [ACC_W-1:0]            acc_q, acc_d;
  logic [ACC_W-1:0]            mcand_q, mcand_d;
  logic [IN_WIDTH-1:0]         mplier_q, mplier_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        sign_q, sign_d;
  logic signed [OUT_WIDTH-1:0] rd_q, rd_d;
  logic                        out_valid_q, out_valid_d;
  logic signed [OUT_WIDTH-1:0] rounded;

  // The most negative operand's magnitude 2^(IN_WIDTH-1) still fits unsigned.
  function automatic logic [IN_WIDTH-1:0] mag_of(input logic [IN_WIDTH-1:0] v);
    return v[IN_WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  fxp_round_sat #(
    .ACC_W    (ACC_W),
    .OUT_WIDTH(OUT_WIDTH),
    .SHIFT    (SHIFT)
  ) u_round_sat (
    .mag_i (acc_q),
    .sign_i(sign_q),
    .res_o (rounded)
  );

  assign in_ready  = (state_q == IDLE);
  assign rd        = rd_q;
  assign out_valid = out_valid_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    rd_d        = rd_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = {{IN_WIDTH{1'b0}}, mag_of(rs1)};
          mplier_d = mag_of(rs2);
          sign_d   = rs1[IN_WIDTH-1] ^ rs2[IN_WIDTH-1];
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = ROUND;
      end
      ROUND: begin
        rd_d        = rounded;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Directed bench for fixed_point_multiplier at IN_WIDTH=OUT_WIDTH=12.
module tb_fixed_point_multiplier;

  localparam int IN_WIDTH  = 12;
  localparam int OUT_WIDTH = 12;
  localparam int LATENCY   = IN_WIDTH + 1;

  logic                        clk = 1'b0;
  logic                        rst;
  logic signed [IN_WIDTH-1:0]  rs1;
  logic signed [IN_WIDTH-1:0]  rs2;
  logic                        in_valid;
  logic                        in_ready;
  logic signed [OUT_WIDTH-1:0] rd;
  logic                        out_valid;
  logic                        out_ready;

  int checks = 0;
  int errors = 0;

  fixed_point_multiplier #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rs1      (rs1),
    .rs2      (rs2),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .rd       (rd),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called just after the accept edge; waits for out_valid at negedges.
  task automatic wait_result(input string tag, input bit scramble);
    int lat;
    bit irdy_bad;
    lat = -1;
    irdy_bad = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (scramble) begin
        rs1 = IN_WIDTH'($urandom);
        rs2 = IN_WIDTH'($urandom);
      end
      if (out_valid) begin
        lat = k;
        break;
      end
      if (in_ready) irdy_bad = 1'b1;
    end
    check({tag, "_latency"}, lat, LATENCY);
    check({tag, "_in_ready_low"}, int'(irdy_bad), 0);
  endtask

  task automatic run_op(input string tag, input int a, input int b, input int exp);
    @(negedge clk);
    rs1      = IN_WIDTH'(a);
    rs2      = IN_WIDTH'(b);
    in_valid = 1'b1;
    check({tag, "_accept_ready"}, int'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(tag, 1'b0);
    check({tag, "_rd"}, int'(rd), exp);
    if (out_ready) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_drain_valid"}, int'(out_valid), 0);
      check({tag, "_drain_ready"}, int'(in_ready), 1);
    end
  endtask

  initial begin
    bit seen;
    int held;
    rst       = 1'b1;
    rs1       = '0;
    rs2       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_rd", int'(rd), 0);
    check("reset_in_ready", int'(in_ready), 1);
    rst = 1'b0;

    run_op("half_sq", 1024, 1024, 512);
    run_op("neg1_sq", -2048, -2048, 2047);
    run_op("neg1_half", -2048, 1024, -1024);
    run_op("round_pos", 3, 1024, 2);
    run_op("round_neg", -3, 1024, -2);
    run_op("mixed", 345, 1860, 313);
    run_op("zero", 0, -5, 0);

    // Backpressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    run_op("bp", 1024, 1024, 512);
    held = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid && rd == 512 && !in_ready) held++;
    end
    check("bp_hold_cycles", held, 5);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_drain_valid", int'(out_valid), 0);
    check("bp_drain_ready", int'(in_ready), 1);

    // Asynchronous reset four cycles into RUN.
    rs1      = 12'sd1024;
    rs2      = -12'sd1024;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_rd", int'(rd), 512 - 512);
    check("midrst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_result", int'(seen), 0);
    run_op("after_rst", 3, 10, 0);

    // Operands scrambled during RUN with in_valid held high.
    out_ready = 1'b0;
    @(negedge clk);
    rs1      = 12'sd345;
    rs2      = 12'sd1860;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rs1 = 12'sd7;
    rs2 = -12'sd9;
    wait_result("scr", 1'b1);
    check("scr_rd", int'(rd), 313);
    held = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      rs1 = IN_WIDTH'($urandom);
      rs2 = IN_WIDTH'($urandom);
      if (out_valid && rd == 313 && !in_ready) held++;
    end
    check("scr_no_second_accept", held, 3);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("scr_drain_valid", int'(out_valid), 0);
    check("scr_drain_ready", int'(in_ready), 1);
    rs1 = 12'sd3;
    rs2 = 12'sd1024;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rs1 = -12'sd2048;
    rs2 = -12'sd2048;
    wait_result("scr2", 1'b0);
    check("scr2_rd", int'(rd), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fixed_point_multiplier.md
Name: fixed_point_multiplier

Overview:
- Sequential signed fixed-point multiplier; the inverse of `fixed_point_divider` in the arithmetic datapath.
- Same Q1.(N-1) operand format: scale 2^(IN_WIDTH-1), so 2048 represents 1.0 at IN_WIDTH=12.
- Radix-2 shift-add on operand magnitudes, then sign fix, round and saturate.
- Valid/ready on input and output so it drops into the same pipeline slots as the divider.

Parameters:
- IN_WIDTH, 12, operand width; Q1.(IN_WIDTH-1) signed.
- OUT_WIDTH, 12, result width; Q1.(OUT_WIDTH-1) signed. Legal range 2 <= OUT_WIDTH <= 2*IN_WIDTH-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- rs1  input  IN_WIDTH  signed multiplicand
- rs2  input  IN_WIDTH  signed multiplier
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- rd  output  OUT_WIDTH  signed rounded/saturated product
- out_valid  output  1  rd holds a result
- out_ready  input  1  consumer takes the result

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rd=0, out_valid=0, accumulator and counter cleared.
  - in_ready=1 once in IDLE.
  - Reset mid-operation discards the operation with no output.
- States: IDLE, RUN, ROUND, DONE. in_ready = (state==IDLE), combinational.
- IDLE:
  - on in_valid & in_ready at edge t0, latch |rs1|, |rs2| as IN_WIDTH-bit unsigned, and sign = rs1[msb]^rs2[msb].
  - Go to RUN, count=0.
  - |-2^(IN_WIDTH-1)| = 2^(IN_WIDTH-1) fits unsigned.
- RUN:
  - each cycle, if multiplier LSB=1, add the shifted multiplicand into the 2*IN_WIDTH-bit accumulator.
  - Shift the multiplier right; count++.
  - After IN_WIDTH cycles (edge t0+IN_WIDTH) go to ROUND. No early termination on zero operands; latency is fixed.
- ROUND:
  - SHIFT = 2*(IN_WIDTH-1) - (OUT_WIDTH-1).
  - mag = (acc + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >> SHIFT. This is round-half-away-from-zero on the magnitude.
  - If sign=0 and mag > 2^(OUT_WIDTH-1)-1, rd = max positive.
  - If sign=1 and mag > 2^(OUT_WIDTH-1), rd = min negative.
  - Otherwise rd = sign ? -mag : mag. A zero magnitude gives rd=0 regardless of sign.
  - Register rd and set out_valid at edge t0+IN_WIDTH+1; go to DONE.
- Latency: out_valid is high in the cycle after edge t0+IN_WIDTH+1, i.e. IN_WIDTH+1 edges after acceptance.
- DONE:
  - rd and out_valid held stable until out_ready=1.
  - On that edge out_valid->0 and state->IDLE. in_ready rises the following cycle; no accept in the same cycle as drain.
- Inputs rs1/rs2 are don't-care except in the accept cycle. Changing them mid-RUN has no effect.
- Throughput: with out_ready tied high, at most one result per IN_WIDTH+3 cycles.

Decomposition:
- Shared package fixed_point_pkg holds:
  - the mult_state_t enum (IDLE/RUN/ROUND/DONE);
  - a localparam function for SHIFT;
  - a sat_max/sat_min helper, reusable by the divider.
- One sub-module, fxp_round_sat: combinational magnitude+sign -> rounded, saturated OUT_WIDTH result, parameterised on input width and SHIFT.

Test Plan:
- Reset, then rs1=1024, rs2=1024 (0.5*0.5) with out_ready=1 -> rd=512, out_valid high the cycle after edge t0+13; in_ready low for the whole operation.
- rs1=-2048, rs2=-2048 (-1*-1) -> rd=2047 (saturate). rs1=-2048, rs2=1024 -> rd=-1024.
- Rounding:
  - rs1=3, rs2=1024 -> rd=2 (1.5 rounds away).
  - rs1=-3, rs2=1024 -> rd=-2.
  - rs1=345, rs2=1860 -> rd=313.
  - rs1=0, rs2=-5 -> rd=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> rd and out_valid stable, in_ready stays 0. Raise out_ready -> out_valid drops, in_ready=1 the next cycle.
- Assert rst 4 cycles into RUN -> out_valid=0, rd=0 immediately (async), no result appears. The next accepted operation (3*10) completes normally with rd=0.
- Change rs1/rs2 every cycle during RUN; in_valid held high throughout -> result reflects only the accepted operands; a second operation is accepted only after drain.
